// File: rtl/msrv32_iadder_arbiter.sv
// Arbitrates the shared immediate adder between the branch unit (pc/rs_1 + imm) and the
// load/store unit (rs_1 + imm), and registers the sum with tag and alignment flag behind valid/ready.
module msrv32_iadder_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter bit ALIGN_CHECK  = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        flush_in,
  input  logic        br_valid_in,
  output logic        br_ready_out,
  input  logic [31:0] br_pc_in,
  input  logic [31:0] br_imm_in,
  input  logic        br_jalr_in,
  input  logic [31:0] br_rs_1_in,
  input  logic        ls_valid_in,
  output logic        ls_ready_out,
  input  logic [31:0] ls_rs_1_in,
  input  logic [31:0] ls_imm_in,
  input  logic [1:0]  ls_size_in,
  output logic [31:0] pc_out,
  output logic [31:0] imm_out,
  output logic [31:0] rs_1_out,
  output logic        iadder_src_out,
  input  logic [31:0] iadder_in,
  output logic        res_valid_out,
  input  logic        res_ready_in,
  output logic [31:0] res_addr_out,
  output logic        res_tag_out,
  output logic        res_misaligned_out
);

  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             grant_ls;
  logic             grant_br;
  logic             can_accept;
  logic             accept;
  logic [31:0]      sum_p0;
  logic             mis_p0;
  logic [CNT_W-1:0] starve_nxt;

  logic             vld_p1;
  logic [31:0]      addr_p1;
  logic             tag_p1;
  logic             mis_p1;

  function automatic logic misalign_chk(input logic [1:0] addr_lo, input logic is_ls,
                                        input logic [1:0] size);
    logic mis;
    mis = 1'b0;
    if (!is_ls) begin
      mis = |addr_lo;
    end else begin
      case (size)
        2'b00:   mis = 1'b0;
        2'b01:   mis = addr_lo[0];
        2'b10:   mis = |addr_lo;
        default: mis = 1'b1;
      endcase
    end
    return mis;
  endfunction

  // Stage p0: arbitration, operand steering and result shaping from the combinational sum
  assign starve_hit   = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_ls     = ls_valid_in & (~br_valid_in | starve_hit);
  assign grant_br     = br_valid_in & ~grant_ls;
  assign can_accept   = rst_n_in & ~flush_in & (~vld_p1 | res_ready_in);
  assign accept       = can_accept & (grant_br | grant_ls);
  assign br_ready_out = can_accept & grant_br;
  assign ls_ready_out = can_accept & grant_ls;

  always_comb begin
    pc_out         = '0;
    imm_out        = '0;
    rs_1_out       = '0;
    iadder_src_out = 1'b0;
    if (grant_ls) begin
      rs_1_out       = ls_rs_1_in;
      imm_out        = ls_imm_in;
      iadder_src_out = 1'b1;
    end else if (grant_br) begin
      imm_out = br_imm_in;
      if (br_jalr_in) begin
        rs_1_out       = br_rs_1_in;
        iadder_src_out = 1'b1;
      end else begin
        pc_out = br_pc_in;
      end
    end
  end

  assign sum_p0 = (grant_br & br_jalr_in) ? {iadder_in[31:1], 1'b0} : iadder_in;
  assign mis_p0 = ALIGN_CHECK ? misalign_chk(sum_p0[1:0], grant_ls, ls_size_in) : 1'b0;

  // A waiting LS request gets forced through after STARVE_LIMIT consecutive BR wins
  always_comb begin
    starve_nxt = '0;
    if (grant_br && ls_valid_in)
      starve_nxt = starve_hit ? starve_cnt : starve_cnt + CNT_W'(1);
  end

  // Stage p1: single-entry output register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      tag_p1     <= 1'b0;
      mis_p1     <= 1'b0;
      starve_cnt <= '0;
    end else if (flush_in) begin
      vld_p1     <= 1'b0;
      starve_cnt <= '0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      addr_p1    <= sum_p0;
      tag_p1     <= grant_ls;
      mis_p1     <= mis_p0;
      starve_cnt <= starve_nxt;
    end else if (vld_p1 && res_ready_in) begin
      vld_p1 <= 1'b0;
    end
  end

  assign res_valid_out      = vld_p1;
  assign res_addr_out       = addr_p1;
  assign res_tag_out        = tag_p1;
  assign res_misaligned_out = mis_p1;

endmodule

// File: tb/tb_msrv32_iadder_arbiter.sv
// Bench for msrv32_iadder_arbiter: per-cycle reference model of arbitration plus a result
// scoreboard, directed scenarios followed by a constrained-random phase.
module tb_msrv32_iadder_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in, flush_in;
  logic        br_valid_in, br_ready_out, br_jalr_in;
  logic [31:0] br_pc_in, br_imm_in, br_rs_1_in;
  logic        ls_valid_in, ls_ready_out;
  logic [31:0] ls_rs_1_in, ls_imm_in;
  logic [1:0]  ls_size_in;
  logic [31:0] pc_out, imm_out, rs_1_out, iadder_in;
  logic        iadder_src_out;
  logic        res_valid_out, res_ready_in, res_tag_out, res_misaligned_out;
  logic [31:0] res_addr_out;

  always #5 clk_in = ~clk_in;

  // Environment adder model
  assign iadder_in = iadder_src_out ? (rs_1_out + imm_out) : (pc_out + imm_out);

  msrv32_iadder_arbiter #(.STARVE_LIMIT(3), .ALIGN_CHECK(1'b1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
    .br_valid_in(br_valid_in), .br_ready_out(br_ready_out), .br_pc_in(br_pc_in),
    .br_imm_in(br_imm_in), .br_jalr_in(br_jalr_in), .br_rs_1_in(br_rs_1_in),
    .ls_valid_in(ls_valid_in), .ls_ready_out(ls_ready_out), .ls_rs_1_in(ls_rs_1_in),
    .ls_imm_in(ls_imm_in), .ls_size_in(ls_size_in),
    .pc_out(pc_out), .imm_out(imm_out), .rs_1_out(rs_1_out), .iadder_src_out(iadder_src_out),
    .iadder_in(iadder_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .res_addr_out(res_addr_out),
    .res_tag_out(res_tag_out), .res_misaligned_out(res_misaligned_out)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        tag;
    logic        mis;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic m_vld    = 1'b0;
  int   m_starve = 0;
  logic acc_br, acc_ls, obs_ls_rdy, obs_br_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_mis(input logic [31:0] a, input logic is_ls, input logic [1:0] sz);
    logic m;
    if (!is_ls) m = (a[1:0] != 2'b00);
    else begin
      case (sz)
        2'b00:   m = 1'b0;
        2'b01:   m = a[0];
        2'b10:   m = (a[1:0] != 2'b00);
        default: m = 1'b1;
      endcase
    end
    return m;
  endfunction

  // One clock: called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    logic g_ls, g_br, can_acc, e_src;
    logic [31:0] e_pc, e_imm, e_rs, s;
    res_t r;
    #1;
    check("res_valid", res_valid_out, m_vld);
    if (m_vld) begin
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        check("res_addr", res_addr_out, sb_q[0].addr);
        check("res_tag", res_tag_out, sb_q[0].tag);
        check("res_mis", res_misaligned_out, sb_q[0].mis);
      end
    end
    g_ls    = ls_valid_in & (~br_valid_in | (m_starve == 3));
    g_br    = br_valid_in & ~g_ls;
    can_acc = rst_n_in & ~flush_in & (~m_vld | res_ready_in);
    obs_br_rdy = br_ready_out;
    obs_ls_rdy = ls_ready_out;
    check("br_ready", br_ready_out, can_acc & g_br);
    check("ls_ready", ls_ready_out, can_acc & g_ls);
    e_pc = '0; e_imm = '0; e_rs = '0; e_src = 1'b0;
    if (g_ls) begin e_rs = ls_rs_1_in; e_imm = ls_imm_in; e_src = 1'b1; end
    else if (g_br) begin
      e_imm = br_imm_in;
      if (br_jalr_in) begin e_rs = br_rs_1_in; e_src = 1'b1; end
      else e_pc = br_pc_in;
    end
    check("pc_out", pc_out, e_pc);
    check("imm_out", imm_out, e_imm);
    check("rs_1_out", rs_1_out, e_rs);
    check("iadder_src", iadder_src_out, e_src);
    acc_br = can_acc & g_br;
    acc_ls = can_acc & g_ls;
    if (acc_ls) begin
      s = ls_rs_1_in + ls_imm_in;
      r = '{addr: s, tag: 1'b1, mis: exp_mis(s, 1'b1, ls_size_in)};
    end else begin
      s = br_jalr_in ? ((br_rs_1_in + br_imm_in) & 32'hFFFF_FFFE) : (br_pc_in + br_imm_in);
      r = '{addr: s, tag: 1'b0, mis: exp_mis(s, 1'b0, 2'b00)};
    end
    @(posedge clk_in);
    if (!rst_n_in || flush_in) begin
      sb_q.delete();
      m_vld    = 1'b0;
      m_starve = 0;
    end else begin
      if (m_vld && res_ready_in) begin
        void'(sb_q.pop_front());
        m_vld = 1'b0;
      end
      if (acc_br || acc_ls) begin
        sb_q.push_back(r);
        m_vld = 1'b1;
        if (acc_ls || !ls_valid_in) m_starve = 0;
        else if (m_starve < 3) m_starve++;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic set_br(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic j, input logic [31:0] rs);
    br_valid_in = v; br_pc_in = pc; br_imm_in = imm; br_jalr_in = j; br_rs_1_in = rs;
  endtask

  task automatic set_ls(input logic v, input logic [31:0] rs, input logic [31:0] imm,
                        input logic [1:0] sz);
    ls_valid_in = v; ls_rs_1_in = rs; ls_imm_in = imm; ls_size_in = sz;
  endtask

  logic [7:0] seq;

  initial begin
    rst_n_in = 1'b0; flush_in = 1'b0; res_ready_in = 1'b1;
    set_br(1'b0, '0, '0, 1'b0, '0);
    set_ls(1'b0, '0, '0, 2'b00);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_valid", res_valid_out, 0);
    check("rst_addr", res_addr_out, 0);
    check("rst_tag", res_tag_out, 0);
    check("rst_mis", res_misaligned_out, 0);
    rst_n_in = 1'b1;

    // 1: plain branch
    set_br(1'b1, 32'h100, 32'h20, 1'b0, '0);
    tick();
    set_br(1'b0, '0, '0, 1'b0, '0);
    check("t1_addr", res_addr_out, 32'h120);
    check("t1_tag", res_tag_out, 0);
    check("t1_mis", res_misaligned_out, 0);
    tick();

    // 2: load/store word then half
    set_ls(1'b1, 32'h1000, 32'h6, 2'b10);
    tick();
    check("t2_addr", res_addr_out, 32'h1006);
    check("t2_tag", res_tag_out, 1);
    check("t2_mis_word", res_misaligned_out, 1);
    set_ls(1'b1, 32'h1000, 32'h6, 2'b01);
    tick();
    set_ls(1'b0, '0, '0, 2'b00);
    check("t2_mis_half", res_misaligned_out, 0);
    tick();

    // 3: starvation guard
    set_br(1'b1, 32'h200, 32'h4, 1'b0, '0);
    set_ls(1'b1, 32'h3000, 32'h8, 2'b10);
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seq = {seq[6:0], obs_ls_rdy};
    end
    check("t3_grant_seq", {24'h0, seq}, 32'h11);
    set_br(1'b0, '0, '0, 1'b0, '0);
    set_ls(1'b0, '0, '0, 2'b00);
    tick();

    // 4: backpressure hold then back-to-back
    res_ready_in = 1'b0;
    set_br(1'b1, 32'h300, 32'h4, 1'b0, '0);
    tick();
    set_br(1'b1, 32'h400, 32'h8, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_rdy", obs_br_rdy, 0);
      check("t4_hold_addr", res_addr_out, 32'h304);
    end
    res_ready_in = 1'b1;
    tick();
    set_br(1'b0, '0, '0, 1'b0, '0);
    check("t4_b2b_valid", res_valid_out, 1);
    check("t4_b2b_addr", res_addr_out, 32'h408);
    tick();

    // 5: JALR mask, then flush of held result
    res_ready_in = 1'b0;
    set_br(1'b1, 32'h5555, 32'h0, 1'b1, 32'h2003);
    tick();
    set_br(1'b0, '0, '0, 1'b0, '0);
    check("t5_addr", res_addr_out, 32'h2002);
    check("t5_mis", res_misaligned_out, 1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("t5_flush_valid", res_valid_out, 0);

    // 6: wraparound, then reset while held with a request pending
    set_br(1'b1, 32'hFFFF_FFFC, 32'h8, 1'b0, '0);
    tick();
    check("t6_wrap", res_addr_out, 32'h4);
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    set_br(1'b0, '0, '0, 1'b0, '0);
    check("t6_rst_valid", res_valid_out, 0);
    check("t6_rst_addr", res_addr_out, 0);
    check("t6_rst_tag", res_tag_out, 0);
    check("t6_rst_mis", res_misaligned_out, 0);
    res_ready_in = 1'b1;
    tick();

    // Random traffic; requesters keep operands stable until accepted
    acc_br = 1'b0; acc_ls = 1'b0;
    for (int i = 0; i < 400; i++) begin
      res_ready_in = ($urandom_range(0, 3) != 0);
      flush_in     = ($urandom_range(0, 31) == 0);
      if (!br_valid_in || acc_br)
        set_br($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom);
      if (!ls_valid_in || acc_ls)
        set_ls($urandom_range(0, 1) == 1, $urandom, $urandom, 2'($urandom_range(0, 3)));
      tick();
    end
    flush_in = 1'b0;
    res_ready_in = 1'b1;
    set_br(1'b0, '0, '0, 1'b0, '0);
    set_ls(1'b0, '0, '0, 2'b00);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
